// File: rtl/scr_base_l3_bk_snp_crdt_tx.sv
// Credit-gated snoop transmitter: buffers snoop requests in an in-order FIFO
// and sends one packed flit per held credit toward the L3 bank snoop queue.
module scr_base_l3_bk_snp_crdt_tx #(
    parameter int DEPTH    = 4,
    parameter int CRDT_MAX = 4,
    parameter int SCRID_W  = 4,
    parameter int TXNID_W  = 8,
    parameter int OPC_W    = 4,
    parameter int SIZE_W   = 3,
    parameter int ADDR_W   = 40,
    localparam int FLIT_W  = SCRID_W + TXNID_W + OPC_W + SIZE_W + ADDR_W,
    localparam int CW      = $clog2(CRDT_MAX + 1),
    localparam int QW      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               snp_val_i,
    output logic               snp_ready_o,
    input  logic [SCRID_W-1:0] snp_scrid_i,
    input  logic [TXNID_W-1:0] snp_txnid_i,
    input  logic [OPC_W-1:0]   snp_opc_i,
    input  logic [SIZE_W-1:0]  snp_size_i,
    input  logic [ADDR_W-1:0]  snp_addr_i,
    output logic               snp_out_val_o,
    output logic [FLIT_W-1:0]  snp_out_flit_o,
    input  logic               snp_out_crdt_i,
    output logic [CW-1:0]      crdt_cnt_o,
    output logic [QW-1:0]      que_cnt_o,
    output logic               crdt_err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [QW-1:0] DEPTH_V = QW'(DEPTH);
    localparam logic [CW-1:0] CMAX_V  = CW'(CRDT_MAX);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [QW-1:0]     que_cnt_q, que_cnt_d;
    logic [CW-1:0]     crdt_cnt_q, crdt_cnt_d;
    logic              out_val_q, out_val_d;
    logic [FLIT_W-1:0] out_flit_q, out_flit_d;
    logic              err_q, err_d;
    logic              push;
    logic              pop;
    logic [FLIT_W-1:0] in_flit;

    assign in_flit = {snp_scrid_i, snp_txnid_i, snp_opc_i,
                      snp_size_i, snp_addr_i};

    // No pop bypass: a full FIFO keeps ready low even while popping.
    assign snp_ready_o = !rst && (que_cnt_q != DEPTH_V);
    assign push        = snp_val_i && snp_ready_o;
    assign pop         = (que_cnt_q != '0) && (crdt_cnt_q != '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        que_cnt_d  = que_cnt_q + QW'(push) - QW'(pop);
        out_val_d  = pop;
        out_flit_d = out_flit_q;
        crdt_cnt_d = crdt_cnt_q;
        err_d      = err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            out_flit_d = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PW'(1);
        end
        // A return while already full saturates and flags the upstream bug.
        if (snp_out_crdt_i && !pop && (crdt_cnt_q == CMAX_V)) begin
            err_d = 1'b1;
        end else begin
            crdt_cnt_d = crdt_cnt_q - CW'(pop) + CW'(snp_out_crdt_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            que_cnt_q  <= '0;
            crdt_cnt_q <= CMAX_V;
            out_val_q  <= 1'b0;
            out_flit_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            que_cnt_q  <= que_cnt_d;
            crdt_cnt_q <= crdt_cnt_d;
            out_val_q  <= out_val_d;
            out_flit_q <= out_flit_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_flit;
        end
    end

    assign snp_out_val_o  = out_val_q;
    assign snp_out_flit_o = out_flit_q;
    assign crdt_cnt_o     = crdt_cnt_q;
    assign que_cnt_o      = que_cnt_q;
    assign crdt_err_o     = err_q;

endmodule

// File: tb/tb_scr_base_l3_bk_snp_crdt_tx.sv
// Scoreboard bench for the credit-gated snoop transmitter.
module tb_scr_base_l3_bk_snp_crdt_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        snp_val_i;
    logic        snp_ready_o;
    logic [3:0]  snp_scrid_i;
    logic [7:0]  snp_txnid_i;
    logic [3:0]  snp_opc_i;
    logic [2:0]  snp_size_i;
    logic [39:0] snp_addr_i;
    logic        snp_out_val_o;
    logic [58:0] snp_out_flit_o;
    logic        snp_out_crdt_i;
    logic [2:0]  crdt_cnt_o;
    logic [2:0]  que_cnt_o;
    logic        crdt_err_o;

    int n_chk   = 0;
    int n_fail  = 0;
    int n_flits = 0;
    int base;
    logic [58:0] exp_q [$];

    scr_base_l3_bk_snp_crdt_tx dut (
        .clk            (clk),
        .rst            (rst),
        .snp_val_i      (snp_val_i),
        .snp_ready_o    (snp_ready_o),
        .snp_scrid_i    (snp_scrid_i),
        .snp_txnid_i    (snp_txnid_i),
        .snp_opc_i      (snp_opc_i),
        .snp_size_i     (snp_size_i),
        .snp_addr_i     (snp_addr_i),
        .snp_out_val_o  (snp_out_val_o),
        .snp_out_flit_o (snp_out_flit_o),
        .snp_out_crdt_i (snp_out_crdt_i),
        .crdt_cnt_o     (crdt_cnt_o),
        .que_cnt_o      (que_cnt_o),
        .crdt_err_o     (crdt_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] s, input logic [7:0] t,
                        input logic [3:0] o, input logic [2:0] z,
                        input logic [39:0] a);
        bit acc;
        acc = 1'b0;
        snp_scrid_i = s;
        snp_txnid_i = t;
        snp_opc_i   = o;
        snp_size_i  = z;
        snp_addr_i  = a;
        snp_val_i   = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = snp_ready_o;
            cyc();
        end
        snp_val_i = 1'b0;
        if (acc) exp_q.push_back({s, t, o, z, a});
        else chk("push_timeout", 64'(acc), 64'd1);
    endtask

    // Monitor: every presented flit must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (snp_out_val_o === 1'b1) begin
                n_flits++;
                if (exp_q.size() == 0)
                    chk("unexpected_flit", 64'(snp_out_flit_o), 64'hDEAD);
                else
                    chk("flit", 64'(snp_out_flit_o), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        snp_val_i = 1'b0;
        snp_out_crdt_i = 1'b0;
        snp_scrid_i = '0;
        snp_txnid_i = '0;
        snp_opc_i = '0;
        snp_size_i = '0;
        snp_addr_i = '0;
        repeat (3) cyc();
        chk("rst_ready", 64'(snp_ready_o), 64'd0);
        chk("rst_val", 64'(snp_out_val_o), 64'd0);
        chk("rst_crdt", 64'(crdt_cnt_o), 64'd4);
        chk("rst_que", 64'(que_cnt_o), 64'd0);
        chk("rst_err", 64'(crdt_err_o), 64'd0);
        chk("rst_flit", 64'(snp_out_flit_o), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 64'(snp_ready_o), 64'd1);

        // single snoop latency and packing
        push(4'h3, 8'hA5, 4'h2, 3'h6, 40'h12_3456_7880);
        chk("lat_t1_val", 64'(snp_out_val_o), 64'd0);
        cyc();
        chk("lat_t2_val", 64'(snp_out_val_o), 64'd1);
        chk("single_flit", 64'(snp_out_flit_o),
            64'({4'h3, 8'hA5, 4'h2, 3'h6, 40'h12_3456_7880}));
        chk("single_crdt", 64'(crdt_cnt_o), 64'd3);
        cyc();
        chk("lat_t3_val", 64'(snp_out_val_o), 64'd0);
        snp_out_crdt_i = 1'b1;
        cyc();
        snp_out_crdt_i = 1'b0;
        chk("restore_crdt", 64'(crdt_cnt_o), 64'd4);
        chk("restore_err", 64'(crdt_err_o), 64'd0);

        // overflow
        snp_out_crdt_i = 1'b1;
        cyc();
        snp_out_crdt_i = 1'b0;
        chk("ovf_crdt", 64'(crdt_cnt_o), 64'd4);
        chk("ovf_err", 64'(crdt_err_o), 64'd1);
        repeat (3) cyc();
        chk("ovf_err_sticky", 64'(crdt_err_o), 64'd1);

        // credit exhaustion
        base = n_flits;
        for (int i = 0; i < 8; i++)
            push(4'(i), 8'(8'h10 + i), 4'(15 - i), 3'(i),
                 40'(64'hAB_0000_0000 + i * 64));
        chk("exh_flits", 64'(n_flits - base), 64'd4);
        chk("exh_que", 64'(que_cnt_o), 64'd4);
        chk("exh_crdt", 64'(crdt_cnt_o), 64'd0);
        chk("exh_ready", 64'(snp_ready_o), 64'd0);
        chk("exh_val", 64'(snp_out_val_o), 64'd0);
        snp_out_crdt_i = 1'b1;
        cyc();
        snp_out_crdt_i = 1'b0;
        chk("pulse_c1_val", 64'(snp_out_val_o), 64'd0);
        chk("pulse_c1_crdt", 64'(crdt_cnt_o), 64'd1);
        cyc();
        chk("pulse_c2_val", 64'(snp_out_val_o), 64'd1);
        chk("pulse_c2_crdt", 64'(crdt_cnt_o), 64'd0);
        chk("pulse_c2_que", 64'(que_cnt_o), 64'd3);
        cyc();
        chk("pulse_c3_val", 64'(snp_out_val_o), 64'd0);
        chk("pulse_flits", 64'(n_flits - base), 64'd5);

        // mid-operation reset drops buffered entries
        exp_q.delete();
        rst = 1'b1;
        cyc();
        chk("mrst_crdt", 64'(crdt_cnt_o), 64'd4);
        chk("mrst_que", 64'(que_cnt_o), 64'd0);
        chk("mrst_val", 64'(snp_out_val_o), 64'd0);
        chk("mrst_ready", 64'(snp_ready_o), 64'd0);
        chk("mrst_err", 64'(crdt_err_o), 64'd0);
        rst = 1'b0;
        base = n_flits;
        repeat (4) cyc();
        chk("mrst_no_flits", 64'(n_flits - base), 64'd0);
        push(4'h5, 8'h3C, 4'h9, 3'h1, 40'hFE_DCBA_9870);
        cyc();
        chk("post_rst_val", 64'(snp_out_val_o), 64'd1);
        chk("post_rst_flit", 64'(snp_out_flit_o),
            64'({4'h5, 8'h3C, 4'h9, 3'h1, 40'hFE_DCBA_9870}));
        chk("post_rst_crdt", 64'(crdt_cnt_o), 64'd3);

        // simultaneous pop and credit return
        push(4'h1, 8'h01, 4'h1, 3'h1, 40'h1);
        repeat (2) cyc();
        chk("sim_pre_crdt", 64'(crdt_cnt_o), 64'd2);
        chk("sim_pre_que", 64'(que_cnt_o), 64'd0);
        push(4'hC, 8'h77, 4'h4, 3'h2, 40'h00_0000_1000);
        snp_out_crdt_i = 1'b1;
        push(4'hD, 8'h78, 4'h5, 3'h3, 40'h00_0000_2000);
        snp_out_crdt_i = 1'b0;
        chk("sim_pop_crdt", 64'(crdt_cnt_o), 64'd2);
        chk("sim_pop_que", 64'(que_cnt_o), 64'd1);
        cyc();
        chk("sim_second_crdt", 64'(crdt_cnt_o), 64'd1);
        chk("sim_second_que", 64'(que_cnt_o), 64'd0);

        repeat (5) cyc();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
